// File: rtl/ac97_pkg.sv
// ac97_pkg: shared AC97 register addresses, idle command and arbiter state encoding
package ac97_pkg;
  localparam logic [7:0] CMD_IDLE_ADDR = 8'h80;
  localparam logic [7:0] REG_MASTER_VOL = 8'h02;
  localparam logic [7:0] REG_AUX_VOL = 8'h04;
  localparam logic [7:0] REG_PCM_VOL = 8'h18;
  localparam logic [7:0] REG_REC_SEL = 8'h1A;
  localparam logic [7:0] REG_REC_GAIN = 8'h1C;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} arb_state_t;
  function automatic logic [7:0] onehot8(input logic [2:0] i);
    return 8'(1) << i;
  endfunction
endpackage

// File: rtl/ac97_cmd_arbiter_if.sv
// ac97_cmd_arbiter_if: requester, frame-strobe and command-slot signals of the arbiter
interface ac97_cmd_arbiter_if #(parameter int NUM_REQ = 4);
  logic ready;
  logic [NUM_REQ-1:0] req;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic [7:0] command_address;
  logic [15:0] command_data;
  logic command_valid;
  logic busy;
  modport master (
    output ready, req, req_addr, req_data,
    input grant, done, command_address, command_data, command_valid, busy
  );
  modport slave (
    input ready, req, req_addr, req_data,
    output grant, done, command_address, command_data, command_valid, busy
  );
endinterface

// File: rtl/ready_edge_sync.sv
// ready_edge_sync: synchronizes the AC97 ready strobe and flags its rising edge
module ready_edge_sync (
  input  logic clock_27mhz,
  input  logic reset,
  input  logic i_ready,
  output logic o_edge
);
  logic [2:0] r_sync;
  logic [1:0] r_fill;
  logic r_armed;
  // shift ready through the synchronizer; arm only once a genuine low has been sampled,
  // so a strobe already high at reset release does not count as an edge
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      r_sync <= '0;
      r_fill <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], i_ready};
      r_fill <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & ~r_sync[1]);
    end
  end
  assign o_edge = r_sync[1] & ~r_sync[2] & r_armed;
endmodule

// File: rtl/ac97_cmd_arbiter.sv
// ac97_cmd_arbiter: round-robin sharing of the AC97 command slot, one command per frame
module ac97_cmd_arbiter import ac97_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter logic [7:0] IDLE_ADDR = CMD_IDLE_ADDR
) (
  input logic clock_27mhz,
  input logic reset,
  ac97_cmd_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic w_frame_edge;
  logic w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic [7:0] w_addr [NUM_REQ];
  logic [15:0] w_data [NUM_REQ];
  arb_state_t r_state;
  logic [IW-1:0] r_last;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [7:0] r_addr;
  logic [15:0] r_data;
  logic r_valid;

  ready_edge_sync u_sync (
    .clock_27mhz(clock_27mhz),
    .reset(reset),
    .i_ready(bus.ready),
    .o_edge(w_frame_edge)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_addr[i] = bus.req_addr[8*i +: 8];
    assign w_data[i] = bus.req_data[16*i +: 16];
  end

  // rotate the search origin to just past the last winner; the nearest requester wins
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_last) + 1 + k) % NUM_REQ);
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // command slot only changes right after a frame edge: retire the held command, then reload
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      r_state <= IDLE;
      r_last <= IW'(NUM_REQ - 1);
      r_grant <= '0;
      r_done <= '0;
      r_addr <= IDLE_ADDR;
      r_data <= '0;
      r_valid <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done <= '0;
      if (w_frame_edge) begin
        if (r_state == HOLD) r_done <= NUM_REQ'(onehot8(3'(r_last)));
        if (w_found) begin
          r_grant <= NUM_REQ'(onehot8(3'(w_win)));
          r_addr <= w_addr[w_win];
          r_data <= w_data[w_win];
          r_valid <= 1'b1;
          r_last <= w_win;
          r_state <= HOLD;
        end else begin
          r_addr <= IDLE_ADDR;
          r_data <= '0;
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      end
    end
  end

  assign bus.grant = r_grant;
  assign bus.done = r_done;
  assign bus.command_address = r_addr;
  assign bus.command_data = r_data;
  assign bus.command_valid = r_valid;
  assign bus.busy = (r_state == HOLD);
endmodule

// File: tb/tb_ac97_cmd_arbiter.sv
// tb_ac97_cmd_arbiter: scoreboard bench for the AC97 command arbiter
module tb_ac97_cmd_arbiter;
  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic [7:0] a;
    logic [15:0] dt;
    logic v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  exp_t q[$];
  logic watch = 1'b0;
  logic dropped = 1'b0;

  ac97_cmd_arbiter_if #(.NUM_REQ(4)) bus ();

  ac97_cmd_arbiter #(.NUM_REQ(4), .IDLE_ADDR(8'h80)) dut (
    .clock_27mhz(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [3:0] g, input logic [3:0] d, input logic [7:0] a, input logic [15:0] dt, input logic v);
    q.push_back('{g: g, d: d, a: a, dt: dt, v: v});
  endfunction

  // monitor: every grant/done pulse must match the next expected event
  always @(negedge clk) begin
    if (bus.grant != 4'b0 || bus.done != 4'b0) begin
      if (q.size() == 0) begin
        check("unexpected_event", {24'h0, bus.grant, bus.done}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("grant", 32'(bus.grant), 32'(e.g));
        check("done", 32'(bus.done), 32'(e.d));
        check("cmd_addr", 32'(bus.command_address), 32'(e.a));
        check("cmd_data", 32'(bus.command_data), 32'(e.dt));
        check("cmd_valid", 32'(bus.command_valid), 32'(e.v));
      end
    end
    if (watch && !bus.command_valid) dropped = 1'b1;
  end

  task automatic pulse();
    @(negedge clk);
    bus.ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    bus.ready = 1'b0;
    bus.req = 4'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_addr", 32'(bus.command_address), 32'h80);
    check("rst_data", 32'(bus.command_data), 32'h0);
    check("rst_valid", 32'(bus.command_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // no requests: three frames, nothing issued
    repeat (3) pulse();
    check("idle_valid", 32'(bus.command_valid), 32'h0);
    check("idle_addr", 32'(bus.command_address), 32'h80);

    // single requester, latency of three cycles
    bus.req = 4'b0010;
    bus.req_addr[15:8] = 8'h02;
    bus.req_data[31:16] = 16'h0808;
    push(4'b0010, 4'b0000, 8'h02, 16'h0808, 1'b1);
    @(negedge clk);
    bus.ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("lat_early_busy", 32'(bus.busy), 32'h0);
    end
    @(negedge clk);
    check("lat_busy", 32'(bus.busy), 32'h1);
    bus.req = 4'b0;
    @(negedge clk);
    bus.ready = 1'b0;
    repeat (6) @(negedge clk);
    push(4'b0000, 4'b0010, 8'h80, 16'h0000, 1'b0);
    pulse();
    check("single_busy_end", 32'(bus.busy), 32'h0);

    // all requesters contend: round-robin from 0 after reset
    do_reset();
    bus.req = 4'b1111;
    bus.req_addr = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    push(4'b0001, 4'b0000, 8'h10, 16'h1000, 1'b1);
    push(4'b0010, 4'b0001, 8'h11, 16'h1001, 1'b1);
    push(4'b0100, 4'b0010, 8'h12, 16'h1002, 1'b1);
    push(4'b1000, 4'b0100, 8'h13, 16'h1003, 1'b1);
    push(4'b0001, 4'b1000, 8'h10, 16'h1000, 1'b1);
    repeat (5) pulse();
    bus.req = 4'b0;
    push(4'b0000, 4'b0001, 8'h80, 16'h0000, 1'b0);
    pulse();

    // one requester back-to-back: done and grant coincide, valid never drops
    bus.req = 4'b0100;
    bus.req_addr[23:16] = 8'h1A;
    bus.req_data[47:32] = 16'h0404;
    push(4'b0100, 4'b0000, 8'h1A, 16'h0404, 1'b1);
    push(4'b0100, 4'b0100, 8'h1A, 16'h0404, 1'b1);
    push(4'b0100, 4'b0100, 8'h1A, 16'h0404, 1'b1);
    pulse();
    watch = 1'b1;
    repeat (2) pulse();
    watch = 1'b0;
    check("b2b_valid_held", 32'(dropped), 32'h0);
    bus.req = 4'b0;
    push(4'b0000, 4'b0100, 8'h80, 16'h0000, 1'b0);
    pulse();

    // reset one cycle after a grant drops the command; priority restarts at 0
    bus.req = 4'b1000;
    bus.req_addr[31:24] = 8'h1C;
    bus.req_data[63:48] = 16'h0C0C;
    push(4'b1000, 4'b0000, 8'h1C, 16'h0C0C, 1'b1);
    @(negedge clk);
    bus.ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.grant[3];
    end
    check("grant3_seen", 32'(got), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    bus.ready = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.command_valid), 32'h0);
    check("mid_rst_addr", 32'(bus.command_address), 32'h80);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    bus.req = 4'b1001;
    bus.req_addr[7:0] = 8'h20;
    bus.req_data[15:0] = 16'h2000;
    push(4'b0001, 4'b0000, 8'h20, 16'h2000, 1'b1);
    pulse();
    bus.req = 4'b0;
    push(4'b0000, 4'b0001, 8'h80, 16'h0000, 1'b0);
    pulse();

    // long ready: one edge only, command frozen while requests change
    bus.req = 4'b0010;
    bus.req_addr[15:8] = 8'h30;
    bus.req_data[31:16] = 16'h3030;
    push(4'b0010, 4'b0000, 8'h30, 16'h3030, 1'b1);
    @(negedge clk);
    bus.ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.req = 4'b0100;
    bus.req_addr[15:8] = 8'h31;
    bus.req_addr[23:16] = 8'h40;
    bus.req_data[47:32] = 16'h4040;
    push(4'b0100, 4'b0010, 8'h40, 16'h4040, 1'b1);
    repeat (496) @(negedge clk);
    check("long_addr", 32'(bus.command_address), 32'h30);
    check("long_data", 32'(bus.command_data), 32'h3030);
    check("long_valid", 32'(bus.command_valid), 32'h1);
    bus.ready = 1'b0;
    repeat (6) @(negedge clk);
    pulse();
    bus.req = 4'b0;
    push(4'b0000, 4'b0100, 8'h80, 16'h0000, 1'b0);
    pulse();

    // ready already high at reset release: no edge until it falls and rises
    bus.req = 4'b0001;
    bus.req_addr[7:0] = 8'h50;
    bus.req_data[15:0] = 16'h5050;
    @(negedge clk);
    bus.ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("high_rel_valid", 32'(bus.command_valid), 32'h0);
    bus.ready = 1'b0;
    repeat (6) @(negedge clk);
    push(4'b0001, 4'b0000, 8'h50, 16'h5050, 1'b1);
    pulse();
    bus.req = 4'b0;
    push(4'b0000, 4'b0001, 8'h80, 16'h0000, 1'b0);
    pulse();

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ac97_cmd_arbiter.md
# ac97_cmd_arbiter

Shares the single AC97 command slot (slot 1 address, slot 2 data) among several register-write requesters, such as the power-up init sequencer, volume control and record-source select. It sits in the `clock_27mhz` domain between the requesters and the `ac97` frame engine. It is paced by the frame engine's `ready` strobe so that each command is stable across the end-of-frame latch point. It issues at most one command per AC97 frame and selects among requesters round-robin.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `IDLE_ADDR`, default 8'h80: address driven when no command is in flight (reset-register read, harmless).

Ports (name, direction, width, meaning):
- `clock_27mhz` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ready` in 1: frame strobe from `ac97`, asynchronous to `clock_27mhz`; high from bit 128 to bit 2 of the next frame.
- `req` in NUM_REQ: per-requester request level.
- `req_addr` in 8*NUM_REQ: requester i address at [8i+7:8i].
- `req_data` in 16*NUM_REQ: requester i data at [16i+15:16i].
- `grant` out NUM_REQ: one-hot, one-cycle pulse when requester i's command is loaded.
- `done` out NUM_REQ: one-hot, one-cycle pulse when requester i's command has been latched by the frame engine.
- `command_address` out 8: to `ac97`.
- `command_data` out 16: to `ac97`.
- `command_valid` out 1: to `ac97`.
- `busy` out 1: a command is in flight.

## Operation
- `ready` is synchronized by two flops. A third flop supports edge detection: `frame_edge` = s2 & ~s3.
- States:
  - IDLE: no command held.
  - HOLD: a command is driven, awaiting latch.
- All command changes occur only in the cycle after `frame_edge`. Between edges, `command_*` are held constant.
- On `frame_edge`:
  - If in HOLD: pulse `done[owner]`. The command presented since the previous edge has now been latched at the end of that frame.
  - Then arbitrate. Search `req` starting at index `(last+1) mod NUM_REQ`, wrapping around.
  - If a winner w is found: load `req_addr`/`req_data` slice w, set `command_valid` = 1, pulse `grant[w]`, set `last` = w, and enter HOLD.
  - If no winner: drive `command_address` = IDLE_ADDR, `command_data` = 0, `command_valid` = 0, and enter IDLE.
- The requester contract: hold `req`, addr and data stable until `grant`. It may drop or change them in the cycle after `grant`. `req` deasserting before grant withdraws the request, with no grant or done.
- If the same requester is the winner at an edge and also in HOLD, `done` and `grant` to that requester assert in the same cycle (back-to-back commands).
- Addresses pass through unmodified, including bit 7 (read flag). This block does not decode addresses.
- `busy` = (state == HOLD).
- Throughput is one command per frame (~20.8 µs at 48 kHz). The sustained worst case per requester is one command every NUM_REQ frames when all requesters contend.

## Timing
- Reset values:
  - `grant` = 0, `done` = 0.
  - `command_address` = IDLE_ADDR, `command_data` = 0, `command_valid` = 0, `busy` = 0.
  - State = IDLE, synchronizer flops = 0.
  - `last` = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-HOLD drops the in-flight command with no `done`. It takes effect on the next clock edge regardless of `ready`.
- Latency from the `ready` input rising to `command_*`/`grant` update is 3 `clock_27mhz` cycles. `done` pulses in the same cycle as that update.
- `ready` held high for many cycles yields exactly one `frame_edge`.
- If `ready` is already high at reset release, no edge occurs until it falls and rises again.

## Structure
- Shared package `ac97_pkg` holds:
  - IDLE_ADDR and the default register addresses (8'h02 master, 8'h04 aux, 8'h18 PCM, 8'h1A record select, 8'h1C record gain).
  - The state encoding (IDLE=0, HOLD=1).
- Sub-module `ready_edge_sync` holds the 3-flop synchronizer and rising-edge detector. It is reused by the sine and square tone generators.
- Round-robin search stays in the arbiter as a combinational rotate-and-priority-encode.

## Test plan
- Reset, then 3 `ready` pulses with `req`=0 → `command_valid` stays 0, `command_address` stays 8'h80, and no `grant`/`done`.
- `req[1]` held with addr 8'h02, data 16'h0808, then one ready edge → 3 cycles later `grant`=4'b0010 and `command_*` = 02/0808/valid. At the next edge, `done`=4'b0010 and IDLE is entered.
- `req`=4'b1111 held continuously with distinct addresses → grant order is 0,1,2,3,0 on successive edges. Each `done` arrives exactly one edge after its `grant`.
- Only `req[2]` held over 3 edges → same-cycle `done[2]` and `grant[2]` at edges 2 and 3, and `command_valid` never drops.
- Reset asserted one cycle after a `grant` → outputs return to reset values next cycle. The following edge produces no `done`, and priority restarts at requester 0.
- `ready` high for 500 cycles, and `req` changed between edges → `command_*` unchanged until the next rising edge, and exactly one `grant` per edge.
